// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract unit. One full-adder slice is
// time-multiplexed over a WIDTH-bit operand pair, LSB first, one bit per clock.
// Operations arrive on a valid/ready start port; results leave on a
// valid/ready result port and stay held in result registers until the next
// completion.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-2:0]   r_s_sh;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_start_ready;
  logic               r_busy;
  logic               r_result_valid;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry_out;
  logic               r_overflow;

  logic               w_fa_a;
  logic               w_fa_b;
  logic               w_fa_sum;
  logic               w_fa_carry;
  logic [WIDTH-1:0]   w_s_next;
  logic               w_last_bit;

  // Single full-adder slice fed by the LSBs of the operand shift registers
  assign w_fa_a     = r_a_sh[0];
  assign w_fa_b     = r_b_sh[0];
  assign w_fa_sum   = w_fa_a ^ w_fa_b ^ r_carry;
  assign w_fa_carry = (w_fa_a & w_fa_b) | (w_fa_a & r_carry) | (w_fa_b & r_carry);

  // Partial sum with the new bit shifted into the MSB; on the last bit this is the full result
  assign w_s_next   = {w_fa_sum, r_s_sh};
  assign w_last_bit = (r_cnt == CNT_W'(WIDTH - 1));

  // Control FSM, datapath shift registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_a_sh         <= '0;
      r_b_sh         <= '0;
      r_s_sh         <= '0;
      r_carry        <= 1'b0;
      r_cnt          <= '0;
      r_start_ready  <= 1'b1;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_sum          <= '0;
      r_carry_out    <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_valid && r_start_ready) begin
            // Subtract is A + ~B + 1: invert B and seed the carry with 1
            r_a_sh        <= a;
            r_b_sh        <= sub ? ~b : b;
            r_carry       <= sub;
            r_cnt         <= '0;
            r_state       <= ST_RUN;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        ST_RUN: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_s_sh  <= w_s_next[WIDTH-1:1];
          r_carry <= w_fa_carry;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last_bit) begin
            // Signed overflow: carry into the MSB differs from carry out of it
            r_sum          <= w_s_next;
            r_carry_out    <= w_fa_carry;
            r_overflow     <= r_carry ^ w_fa_carry;
            r_state        <= ST_DONE;
            r_result_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (result_ready) begin
            r_state        <= ST_IDLE;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_start_ready  <= 1'b1;
          end
        end
        default: begin
          r_state        <= ST_IDLE;
          r_result_valid <= 1'b0;
          r_busy         <= 1'b0;
          r_start_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign start_ready  = r_start_ready;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign sum          = r_sum;
  assign carry_out    = r_carry_out;
  assign overflow     = r_overflow;

endmodule
